// File: rtl/drygascon_pkg.sv
// Shared definitions for the drygascon128 block feeder.
// - Domain-separation (ds) bit positions and a helper to pack them.
// - Block / R geometry in 32-bit words, padding byte.
// - Feeder FSM state encoding.
package drygascon_pkg;

  localparam int BLOCK_WORDS = 4;
  localparam int R_WORDS     = 4;

  localparam int DS_PADDED = 0;
  localparam int DS_FINAL  = 1;
  localparam int DS_DOM_LO = 2;
  localparam int DS_DOM_HI = 3;

  localparam logic [7:0] PAD_BYTE = 8'h01;

  typedef enum logic [2:0] {
    S_COLLECT,
    S_WRITE,
    S_START,
    S_WAIT_LO,
    S_WAIT_HI,
    S_RD_DLY,
    S_RD_CAP,
    S_RD_OUT
  } feed_state_e;

  function automatic logic [3:0] make_ds(input logic [1:0] dom, input logic fin,
                                         input logic padded);
    logic [3:0] ds;
    ds                      = '0;
    ds[DS_DOM_HI:DS_DOM_LO] = dom;
    ds[DS_FINAL]            = fin;
    ds[DS_PADDED]           = padded;
    return ds;
  endfunction

endpackage

// File: rtl/drygascon_pad_word.sv
// Masks one little-endian message word to its valid bytes and optionally
// inserts the 10* padding byte right after the last valid byte.
// Ports:
//   word        in  32  raw message word, byte 0 in [7:0]
//   nbytes      in  3   valid bytes (0..4; larger values behave as 4)
//   pad_en      in  1   this word ends the message, padding may land here
//   padded_word out 32  masked word with PAD_BYTE inserted when it fits
//   pad_used    out 1   PAD_BYTE was placed inside this word
module drygascon_pad_word
  import drygascon_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  nbytes,
  input  logic        pad_en,
  output logic [31:0] padded_word,
  output logic        pad_used
);

  always_comb begin
    padded_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < nbytes)
        padded_word[8*i +: 8] = word[8*i +: 8];
      else if (pad_en && 3'(i) == nbytes)
        padded_word[8*i +: 8] = PAD_BYTE;
    end
    pad_used = pad_en && (nbytes < 3'd4);
  end

endmodule

// File: rtl/drygascon128_block_feeder.sv
// Upstream sequencer for the drygascon128 core: packs a 32-bit message
// stream into 128-bit padded blocks, loads each block into the core, starts
// it, waits for completion and streams R back out.
// Ports:
//   clk, rst (sync, active high), clk_en (global enable)
//   s_data/s_bytes/s_last/s_dom/s_valid/s_ready : message input stream
//   core_din/core_ds/core_wr_i/core_start/core_rd_r : drive the core
//   core_dout/core_idle : core read data (registered) and idle flag
//   m_data/m_last/m_valid/m_ready : R output stream, R[31:0] first
//   busy : message in progress
module drygascon128_block_feeder
  import drygascon_pkg::*;
#(
  parameter int DOM_WIDTH = 2,
  parameter int EMIT_ALL  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic [31:0]          s_data,
  input  logic [2:0]           s_bytes,
  input  logic                 s_last,
  input  logic [DOM_WIDTH-1:0] s_dom,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [31:0]          core_din,
  output logic [3:0]           core_ds,
  output logic                 core_wr_i,
  output logic                 core_start,
  output logic                 core_rd_r,
  input  logic [31:0]          core_dout,
  input  logic                 core_idle,
  output logic [31:0]          m_data,
  output logic                 m_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy
);

  feed_state_e                  state;
  logic [BLOCK_WORDS-1:0][31:0] blk;
  logic [1:0]                   w;      // collect index, reused as write index
  logic [1:0]                   r_idx;
  logic [1:0]                   dom_q;
  logic                         fin_q;
  logic                         pad_q;
  logic [1:0]                   dom_in;
  logic [31:0]                  pad_out;
  logic                         pad_used;
  logic                         accept;

  if (DOM_WIDTH >= 2) begin : g_dom
    assign dom_in = s_dom[1:0];
  end else begin : g_dom_narrow
    assign dom_in = {1'b0, s_dom};
  end

  assign accept = (state == S_COLLECT) && s_valid && s_ready;

  drygascon_pad_word u_pad (
    .word        (s_data),
    .nbytes      (s_bytes),
    .pad_en      (s_last),
    .padded_word (pad_out),
    .pad_used    (pad_used)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_COLLECT;
      blk        <= '0;
      w          <= '0;
      r_idx      <= '0;
      dom_q      <= '0;
      fin_q      <= 1'b0;
      pad_q      <= 1'b0;
      s_ready    <= 1'b0;
      core_din   <= '0;
      core_ds    <= '0;
      core_wr_i  <= 1'b0;
      core_start <= 1'b0;
      core_rd_r  <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      m_valid    <= 1'b0;
      busy       <= 1'b0;
    end else if (clk_en) begin
      unique case (state)
        S_COLLECT: begin
          s_ready <= 1'b1;
          if (accept) begin
            blk[w] <= pad_out;
            // Full last word before the block is full: pad opens the next word.
            if (s_last && !pad_used && w != 2'(BLOCK_WORDS-1))
              blk[w + 2'd1] <= {24'd0, PAD_BYTE};
            if (!busy) dom_q <= dom_in;
            busy <= 1'b1;
            if (s_last || w == 2'(BLOCK_WORDS-1)) begin
              state   <= S_WRITE;
              s_ready <= 1'b0;
              fin_q   <= s_last;
              // Only a last block holding exactly 16 data bytes goes unpadded.
              pad_q   <= s_last && (pad_used || w != 2'(BLOCK_WORDS-1));
              w       <= '0;
            end else begin
              w <= w + 2'd1;
            end
          end
        end
        S_WRITE: begin
          // Shifting the buffer out leaves it zeroed for the next block.
          core_wr_i <= 1'b1;
          core_din  <= blk[0];
          blk       <= blk >> 32;
          w         <= w + 2'd1;
          if (w == 2'(BLOCK_WORDS-1)) state <= S_START;
        end
        S_START: begin
          core_wr_i  <= 1'b0;
          core_start <= 1'b1;
          core_ds    <= make_ds(dom_q, fin_q, pad_q);
          state      <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          core_start <= 1'b0;
          if (!core_idle) state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (core_idle) begin
            if (fin_q || EMIT_ALL != 0) begin
              core_rd_r <= 1'b1;
              r_idx     <= '0;
              state     <= S_RD_DLY;
            end else begin
              s_ready <= 1'b1;
              state   <= S_COLLECT;
            end
          end
        end
        S_RD_DLY: begin
          // Core registers dout on this edge; capture follows next edge.
          core_rd_r <= 1'b0;
          state     <= S_RD_CAP;
        end
        S_RD_CAP: begin
          m_data  <= core_dout;
          m_valid <= 1'b1;
          m_last  <= (r_idx == 2'(R_WORDS-1));
          state   <= S_RD_OUT;
        end
        S_RD_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (r_idx == 2'(R_WORDS-1)) begin
              s_ready <= 1'b1;
              state   <= S_COLLECT;
              if (fin_q) busy <= 1'b0;
            end else begin
              r_idx     <= r_idx + 2'd1;
              core_rd_r <= 1'b1;
              state     <= S_RD_DLY;
            end
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_drygascon128_block_feeder.sv
module tb_drygascon128_block_feeder;

  logic        clk = 1'b0;
  logic        rst, clk_en, m_ready;
  logic [31:0] s_data;
  logic [2:0]  s_bytes;
  logic        s_last, s_valid, s_ready;
  logic [1:0]  s_dom;
  logic [31:0] core_din, core_dout, m_data;
  logic [3:0]  core_ds;
  logic        core_wr_i, core_start, core_rd_r, core_idle;
  logic        m_last, m_valid, busy;

  always #5 clk = ~clk;

  drygascon128_block_feeder #(.DOM_WIDTH(2), .EMIT_ALL(0)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .s_data(s_data), .s_bytes(s_bytes), .s_last(s_last), .s_dom(s_dom),
    .s_valid(s_valid), .s_ready(s_ready),
    .core_din(core_din), .core_ds(core_ds), .core_wr_i(core_wr_i),
    .core_start(core_start), .core_rd_r(core_rd_r),
    .core_dout(core_dout), .core_idle(core_idle),
    .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy)
  );

  int  nvec = 0, nerr = 0;
  bit  en_rand = 1'b0;
  int  mr_mode = 0;        // 0 ready, 1 random, 2 held low
  logic [31:0] salt [4];

  // clk_en / m_ready change just after posedge so they are stable around negedge
  initial begin
    clk_en  = 1'b1;
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      clk_en  = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_ready = (mr_mode == 0) ? 1'b1 : (mr_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
    end
  end

  // Core stand-in: stores written words, runs a random time, returns word^salt.
  logic [31:0] cblk [4];
  logic [1:0]  cwi, cri;
  int          ccnt;
  always @(posedge clk) begin
    if (rst) begin
      core_idle <= 1'b1; core_dout <= '0; cwi <= '0; cri <= '0; ccnt <= 0;
    end else if (clk_en) begin
      if (core_wr_i) begin cblk[cwi] <= core_din; cwi <= cwi + 2'd1; end
      if (core_start) begin
        core_idle <= 1'b0; ccnt <= $urandom_range(2, 6); cri <= '0;
      end else if (!core_idle) begin
        if (ccnt == 1) core_idle <= 1'b1;
        ccnt <= ccnt - 1;
      end
      if (core_rd_r) begin core_dout <= cblk[cri] ^ salt[cri]; cri <= cri + 2'd1; end
    end
  end

  // Monitors
  logic [31:0] wr_q[$], ds_q[$], out_q[$], outl_q[$];
  int rd_cnt = 0, first_out_ds = -1;
  int viol_1hot = 0, viol_rdy = 0, viol_frz = 0, viol_stall = 0;
  logic [74:0] snap, p_snap;
  logic p_en = 1'b1, p_rst = 1'b1, p_mv = 1'b0, p_acc = 1'b0;
  logic [31:0] p_md;
  always begin
    @(negedge clk); #2;
    snap = {s_ready, core_din, core_ds, core_wr_i, core_start, core_rd_r,
            m_data, m_last, m_valid, busy};
    if (!p_rst && !p_en && snap !== p_snap) viol_frz++;
    if (!p_rst && p_mv && !p_acc && (m_valid !== 1'b1 || m_data !== p_md)) viol_stall++;
    if (int'(core_wr_i) + int'(core_start) + int'(core_rd_r) > 1) viol_1hot++;
    if (s_ready && (core_wr_i || core_start || core_rd_r || m_valid)) viol_rdy++;
    if (!rst && clk_en) begin
      if (core_wr_i) wr_q.push_back(core_din);
      if (core_start) ds_q.push_back(32'(core_ds));
      if (core_rd_r) rd_cnt++;
      if (m_valid && m_ready) begin
        if (out_q.size() == 0) first_out_ds = ds_q.size();
        out_q.push_back(m_data);
        outl_q.push_back(32'(m_last));
      end
    end
    p_snap = snap; p_en = clk_en; p_rst = rst;
    p_mv = m_valid; p_md = m_data; p_acc = m_ready && clk_en;
  end

  // Reference model: padding and block split from the byte-level rules.
  logic [31:0] exp_wr[$], exp_ds[$], exp_r[$];
  task automatic ref_model(input logic [7:0] msg[$], input logic [1:0] dom);
    logic [7:0] p[$];
    bit pad;
    int nb;
    p = msg;
    exp_wr.delete(); exp_ds.delete(); exp_r.delete();
    pad = (msg.size() % 16 != 0) || (msg.size() == 0);
    if (pad) begin
      p.push_back(8'h01);
      while (p.size() % 16 != 0) p.push_back(8'h00);
    end
    nb = p.size() / 16;
    for (int i = 0; i < p.size() / 4; i++)
      exp_wr.push_back({p[4*i+3], p[4*i+2], p[4*i+1], p[4*i]});
    for (int b = 0; b < nb; b++)
      exp_ds.push_back(32'(dom) * 4 + ((b == nb-1) ? 2 : 0) + ((b == nb-1 && pad) ? 1 : 0));
    for (int i = 0; i < 4; i++) exp_r.push_back(exp_wr[4*(nb-1)+i] ^ salt[i]);
  endtask

  function automatic int qdiff(input logic [31:0] a[$], input logic [31:0] b[$]);
    int n = 0;
    if (a.size() != b.size()) return -1;
    foreach (a[i]) if (a[i] !== b[i]) n++;
    return n;
  endfunction

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic clear_mon();
    wr_q.delete(); ds_q.delete(); out_q.delete(); outl_q.delete();
    rd_cnt = 0; first_out_ds = -1;
  endtask

  task automatic send_msg(input logic [7:0] msg[$], input logic [1:0] dom,
                          input int nmax, input bit gaps, output bit ok);
    int len, nw, cnt, nb, t;
    logic [31:0] d;
    bit acc;
    len = msg.size();
    nw  = (len == 0) ? 1 : (len + 3) / 4;
    cnt = (nmax >= 0) ? nmax : nw;
    ok  = 1'b1;
    for (int k = 0; k < cnt; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      nb = (k == nw-1) ? len - 4*k : 4;
      d  = $urandom;  // junk in bytes beyond nb must be masked
      for (int b = 0; b < nb; b++) d[8*b +: 8] = msg[4*k+b];
      s_data = d; s_bytes = 3'(nb); s_last = (k == nw-1);
      s_dom = (k == 0) ? dom : 2'($urandom_range(0, 3));
      s_valid = 1'b1;
      t = 0;
      forever begin
        acc = s_ready && clk_en;
        step();
        if (acc) break;
        if (++t > 5000) begin ok = 1'b0; break; end
      end
      s_valid = 1'b0;
      if (!ok) break;
    end
  endtask

  task automatic wait_done(output bit ok);
    int t = 0;
    ok = 1'b1;
    while (busy || out_q.size() < 4) begin
      step();
      if (++t > 3000) begin ok = 1'b0; break; end
    end
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_bytes = '0; s_last = 1'b0; s_dom = '0;
    repeat (3) step();
    nvec++; if ({s_ready, core_wr_i, core_start, core_rd_r, m_valid, m_last, busy} !== 7'b0) begin
      nerr++; $display("FAIL reset_flags: got %b want 0000000",
        {s_ready, core_wr_i, core_start, core_rd_r, m_valid, m_last, busy}); end
    nvec++; if (core_din !== 32'h0) begin nerr++; $display("FAIL reset_din: got %h want 0", core_din); end
    nvec++; if (core_ds !== 4'h0) begin nerr++; $display("FAIL reset_ds: got %h want 0", core_ds); end
    nvec++; if (m_data !== 32'h0) begin nerr++; $display("FAIL reset_mdata: got %h want 0", m_data); end
    rst = 1'b0;
    step();
    nvec++; if (s_ready !== 1'b1) begin nerr++; $display("FAIL reset_sready_rise: got %b want 1", s_ready); end
  endtask

  task automatic test_block16();
    logic [7:0] msg[$];
    bit ok1, ok2;
    for (int i = 0; i < 16; i++) msg.push_back(8'(i));
    clear_mon(); ref_model(msg, 2'd1);
    send_msg(msg, 2'd1, -1, 1'b0, ok1); wait_done(ok2);
    nvec++; if (!(ok1 && ok2)) begin nerr++; $display("FAIL b16_timeout: got %b%b want 11", ok1, ok2); end
    nvec++; if (qdiff(wr_q, exp_wr) != 0) begin nerr++; $display("FAIL b16_writes: got %0d words diff %0d want %0d", wr_q.size(), qdiff(wr_q, exp_wr), exp_wr.size()); end
    nvec++; if (wr_q.size() < 4 || wr_q[0] !== 32'h03020100 || wr_q[3] !== 32'h0F0E0D0C) begin nerr++; $display("FAIL b16_word_order: got %0d words want 03020100..0F0E0D0C", wr_q.size()); end
    nvec++; if (ds_q.size() != 1 || ds_q[0] !== 32'h6) begin nerr++; $display("FAIL b16_ds: got %0d starts want one ds=0110", ds_q.size()); end
    nvec++; if (qdiff(out_q, exp_r) != 0) begin nerr++; $display("FAIL b16_r: got %0d words want %0d", out_q.size(), exp_r.size()); end
    nvec++; if (outl_q.size() != 4 || outl_q[3] !== 32'h1 || (outl_q[0] | outl_q[1] | outl_q[2]) !== 32'h0) begin nerr++; $display("FAIL b16_mlast: got %0d flags want 0001", outl_q.size()); end
    nvec++; if (rd_cnt != 4) begin nerr++; $display("FAIL b16_rdcnt: got %0d want 4", rd_cnt); end
  endtask

  task automatic test_short();
    logic [7:0] msg[$];
    bit ok1, ok2;
    msg = '{8'hDD, 8'hCC};
    clear_mon(); ref_model(msg, 2'd0);
    send_msg(msg, 2'd0, -1, 1'b0, ok1); wait_done(ok2);
    nvec++; if (!(ok1 && ok2)) begin nerr++; $display("FAIL short_timeout: got %b%b want 11", ok1, ok2); end
    nvec++; if (wr_q.size() != 4 || wr_q[0] !== 32'h0001CCDD || (wr_q[1] | wr_q[2] | wr_q[3]) !== 32'h0) begin nerr++; $display("FAIL short_writes: got %0d words first %h want 0001ccdd,0,0,0", wr_q.size(), wr_q.size() ? wr_q[0] : 32'hx); end
    nvec++; if (ds_q.size() != 1 || ds_q[0] !== 32'h3) begin nerr++; $display("FAIL short_ds: got %0d starts want ds=0011", ds_q.size()); end
    nvec++; if (qdiff(out_q, exp_r) != 0) begin nerr++; $display("FAIL short_r: got %0d words want 4", out_q.size()); end
  endtask

  task automatic test_empty();
    logic [7:0] msg[$];
    bit ok1, ok2;
    clear_mon(); ref_model(msg, 2'd0);
    send_msg(msg, 2'd0, -1, 1'b0, ok1); wait_done(ok2);
    nvec++; if (!(ok1 && ok2)) begin nerr++; $display("FAIL empty_timeout: got %b%b want 11", ok1, ok2); end
    nvec++; if (wr_q.size() != 4 || wr_q[0] !== 32'h00000001 || (wr_q[1] | wr_q[2] | wr_q[3]) !== 32'h0) begin nerr++; $display("FAIL empty_writes: got %0d words want 00000001,0,0,0", wr_q.size()); end
    nvec++; if (ds_q.size() != 1 || ds_q[0] !== 32'h3) begin nerr++; $display("FAIL empty_ds: got %0d starts want ds=0011", ds_q.size()); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL empty_busy: got %b want 0", busy); end
  endtask

  task automatic test_two_block();
    logic [7:0] msg[$];
    bit ok1, ok2;
    for (int i = 0; i < 32; i++) msg.push_back(8'($urandom));
    clear_mon(); ref_model(msg, 2'd0);
    send_msg(msg, 2'd0, -1, 1'b1, ok1); wait_done(ok2);
    nvec++; if (!(ok1 && ok2)) begin nerr++; $display("FAIL two_timeout: got %b%b want 11", ok1, ok2); end
    nvec++; if (ds_q.size() != 2 || ds_q[0] !== 32'h0 || ds_q[1] !== 32'h2) begin nerr++; $display("FAIL two_ds: got %0d starts want 0000,0010", ds_q.size()); end
    nvec++; if (qdiff(wr_q, exp_wr) != 0) begin nerr++; $display("FAIL two_writes: got %0d words want 8", wr_q.size()); end
    nvec++; if (first_out_ds != 2) begin nerr++; $display("FAIL two_r_after_final: got R after %0d starts want 2", first_out_ds); end
    nvec++; if (qdiff(out_q, exp_r) != 0 || rd_cnt != 4) begin nerr++; $display("FAIL two_r: got %0d words rd %0d want 4/4", out_q.size(), rd_cnt); end
  endtask

  task automatic test_stall();
    logic [7:0] msg[$];
    bit ok1, ok2;
    int t = 0;
    for (int i = 0; i < 18; i++) msg.push_back(8'($urandom));
    en_rand = 1'b1; mr_mode = 2;
    clear_mon(); ref_model(msg, 2'd2);
    send_msg(msg, 2'd2, -1, 1'b1, ok1);
    while (m_valid !== 1'b1 && t < 3000) begin step(); t++; end
    repeat (10) step();
    nvec++; if (m_valid !== 1'b1 || m_data !== exp_r[0] || out_q.size() != 0) begin nerr++; $display("FAIL stall_hold: got v=%b d=%h n=%0d want v=1 d=%h n=0", m_valid, m_data, out_q.size(), exp_r[0]); end
    mr_mode = 1;
    wait_done(ok2);
    nvec++; if (!(ok1 && ok2)) begin nerr++; $display("FAIL stall_timeout: got %b%b want 11", ok1, ok2); end
    nvec++; if (qdiff(out_q, exp_r) != 0) begin nerr++; $display("FAIL stall_r: got %0d words diff %0d want 4", out_q.size(), qdiff(out_q, exp_r)); end
    nvec++; if (rd_cnt != 4) begin nerr++; $display("FAIL stall_rdcnt: got %0d want 4", rd_cnt); end
    nvec++; if (qdiff(ds_q, exp_ds) != 0) begin nerr++; $display("FAIL stall_ds: got %0d starts want %0d", ds_q.size(), exp_ds.size()); end
    en_rand = 1'b0; mr_mode = 0;
    step();
  endtask

  task automatic test_rst_mid();
    logic [7:0] msg[$], msg2[$];
    bit ok1, ok2;
    for (int i = 0; i < 16; i++) msg.push_back(8'($urandom));
    for (int i = 0; i < 7; i++) msg2.push_back(8'($urandom));
    clear_mon();
    send_msg(msg, 2'd3, 2, 1'b0, ok1);
    rst = 1'b1; repeat (2) step();
    nvec++; if ({s_ready, core_wr_i, core_start, core_rd_r, m_valid, m_last, busy} !== 7'b0 || core_din !== 0 || m_data !== 0 || core_ds !== 0) begin
      nerr++; $display("FAIL rstmid_outputs: got flags %b want 0", {s_ready, core_wr_i, core_start, core_rd_r, m_valid, m_last, busy}); end
    rst = 1'b0; repeat (10) step();
    nvec++; if (wr_q.size() != 0 || ds_q.size() != 0) begin nerr++; $display("FAIL rstmid_no_write: got %0d writes %0d starts want 0/0", wr_q.size(), ds_q.size()); end
    ref_model(msg2, 2'd1);
    send_msg(msg2, 2'd1, -1, 1'b0, ok1); wait_done(ok2);
    nvec++; if (!(ok1 && ok2) || qdiff(wr_q, exp_wr) != 0 || qdiff(ds_q, exp_ds) != 0 || qdiff(out_q, exp_r) != 0) begin
      nerr++; $display("FAIL rstmid_next_msg: got %0d writes %0d starts %0d R want %0d/%0d/4", wr_q.size(), ds_q.size(), out_q.size(), exp_wr.size(), exp_ds.size()); end
  endtask

  task automatic test_random();
    logic [7:0] msg[$];
    logic [1:0] dom;
    bit ok1, ok2;
    en_rand = 1'b1; mr_mode = 1;
    for (int n = 0; n < 8; n++) begin
      msg.delete();
      repeat ($urandom_range(0, 40)) msg.push_back(8'($urandom));
      dom = 2'($urandom_range(0, 3));
      clear_mon(); ref_model(msg, dom);
      send_msg(msg, dom, -1, 1'b1, ok1); wait_done(ok2);
      nvec++; if (!(ok1 && ok2) || qdiff(wr_q, exp_wr) != 0) begin nerr++; $display("FAIL rand_writes[%0d]: len %0d got %0d words want %0d", n, msg.size(), wr_q.size(), exp_wr.size()); end
      nvec++; if (qdiff(ds_q, exp_ds) != 0) begin nerr++; $display("FAIL rand_ds[%0d]: len %0d got %0d starts want %0d", n, msg.size(), ds_q.size(), exp_ds.size()); end
      nvec++; if (qdiff(out_q, exp_r) != 0 || rd_cnt != 4) begin nerr++; $display("FAIL rand_r[%0d]: got %0d words rd %0d want 4/4", n, out_q.size(), rd_cnt); end
    end
    en_rand = 1'b0; mr_mode = 0;
    step();
  endtask

  task automatic test_invariants();
    nvec++; if (viol_1hot != 0) begin nerr++; $display("FAIL inv_onehot: got %0d cycles want 0", viol_1hot); end
    nvec++; if (viol_rdy != 0) begin nerr++; $display("FAIL inv_sready_busy: got %0d cycles want 0", viol_rdy); end
    nvec++; if (viol_frz != 0) begin nerr++; $display("FAIL inv_clk_en_freeze: got %0d cycles want 0", viol_frz); end
    nvec++; if (viol_stall != 0) begin nerr++; $display("FAIL inv_m_stable: got %0d cycles want 0", viol_stall); end
  endtask

  initial begin
    foreach (salt[i]) salt[i] = $urandom;
    test_reset();
    test_block16();
    test_short();
    test_empty();
    test_two_block();
    test_stall();
    test_rst_mid();
    test_random();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/drygascon128_block_feeder.md
Name: drygascon128_block_feeder

Overview:
- Upstream sequencer for the drygascon128 core.
- Accepts a 32-bit little-endian message stream (valid/ready), assembles 128-bit blocks, applies 10* padding and derives the 4-bit domain-separation value.
- Writes each block into the core over its wr_i/din port, pulses start and waits for completion.
- Reads R back with rd_r and emits it as a 32-bit output stream when requested.

Parameters:
- DOM_WIDTH, 2, width of domain field supplied per message.
- EMIT_ALL, 0, 1 = emit R after every block; 0 = emit R only after the final block.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- clk_en  in  1  global clock enable; no state changes when low.
- s_data  in  32  message word, byte 0 in bits [7:0].
- s_bytes  in  3  valid bytes in word: 4 normally; 0..4 allowed only with s_last.
- s_last  in  1  final word of message.
- s_dom  in  DOM_WIDTH  domain, sampled on the first word of a message.
- s_valid  in  1  input word valid.
- s_ready  out  1  feeder accepts a word.
- core_din  out  32  to core din.
- core_ds  out  4  to core ds.
- core_wr_i  out  1  to core wr_i.
- core_start  out  1  to core start.
- core_rd_r  out  1  to core rd_r.
- core_dout  in  32  from core dout; registered, valid one enabled cycle after rd_r.
- core_idle  in  1  from core idle.
- m_data  out  32  R word, R[31:0] first.
- m_last  out  1  marks the 4th R word.
- m_valid  out  1  output valid.
- m_ready  in  1  output accepted.
- busy  out  1  high from the first accepted word until the final block completes (R emitted, if applicable).

Behaviour:
- All register updates occur only on posedge clk with clk_en=1; rst=1 wins over every other condition.
- Reset values: s_ready=0, core_wr_i=0, core_start=0, core_rd_r=0, core_din=0, core_ds=0, m_valid=0, m_last=0, m_data=0, busy=0. FSM = COLLECT, word index = 0, block buffer = 0. s_ready rises the first enabled cycle after reset.
- COLLECT:
  - s_ready=1. A word is accepted on s_valid&s_ready.
  - The word is stored at index w; bytes at or beyond s_bytes are zeroed.
  - A full block (w=3 accepted) or any s_last moves the FSM to WRITE.
  - Padding: if the block holds fewer than 16 data bytes, byte 0x01 goes at the first free position, zeros after it, and padded=1.
  - s_bytes=0 with s_last at w=0 yields block 0x01 then 15 zero bytes (empty message).
  - A last block of exactly 16 bytes is unpadded (padded=0).
  - Unused words after s_last are zero.
- WRITE: 4 consecutive enabled cycles with core_wr_i=1, core_din = word 0..3 in order; s_ready=0.
- START: one cycle with core_start=1 and core_ds = {dom[1:0], final, padded}. final=1 only for the s_last block; padded=0 for non-final blocks.
- WAIT_LO: wait for core_idle=0. WAIT_HI: wait for core_idle=1.
- READ: entered when R is to be emitted (final block, or EMIT_ALL=1).
  - core_rd_r high for 1 cycle per word.
  - The next word is requested only after the previous one has been accepted on m_valid&m_ready.
  - m_data is loaded from core_dout on the cycle after rd_r.
  - m_last=1 on word 3.
  - m_valid holds, with data stable, until m_ready.
- Return to COLLECT: w is cleared, and busy drops after the final block.
- Invariant: at most one of core_wr_i, core_start, core_rd_r is high in any cycle.
- Latency:
  - Last word accepted to core_start: 5 enabled cycles (COLLECT→WRITE edge + 4 writes).
  - core_idle rising to first m_valid: 2 cycles.
- Boundary conditions:
  - s_valid during WRITE/START/WAIT/READ is not accepted (s_ready=0).
  - clk_en low freezes everything, including handshake outputs.
  - rst mid-block discards the partial block, with no write to the core. If the core is mid-run, the core is reset by the same rst.
  - m_ready held low stalls indefinitely without losing data.

Decomposition:
- Shared package drygascon_pkg:
  - DS field positions (DS_PADDED=0, DS_FINAL=1, DS_DOM=3:2).
  - BLOCK_WORDS=4, R_WORDS=4.
  - PAD_BYTE=8'h01.
  - FSM state encoding.
- One natural sub-module: drygascon_pad_word. It is combinational: word, byte count and pad-position flag in; masked/padded word and pad-consumed flag out.

Test Plan:
- Reset then 4 words 00010203…0C0D0E0F with s_last, dom=1 → 4 wr_i with those words, start with ds=4'b0110, one R burst of 4 words, m_last on 4th.
- Single word 0xAABBCCDD, s_bytes=2, s_last → core_din 0x0001CCDD, 0, 0, 0; ds padded=1, final=1.
- Empty message (s_bytes=0, s_last, dom=0) → core_din 0x00000001, 0, 0, 0; ds=4'b0011.
- 32-byte message, EMIT_ALL=0 → first block ds=4'b0000 with no R output; second block ds=4'b0010 followed by R burst. s_ready=0 throughout the first block's processing.
- m_ready held low 10 cycles then toggled, with random clk_en gaps → R words exact and in order, none duplicated, rd_r count = 4.
- rst asserted after 2 accepted words → no wr_i/start issued, all outputs return to reset values, next message processed correctly.
